strip_scheduler: RTL and testbench
==================================

STRIP_SCHEDULER -- requirements
Module: strip_scheduler

Interface
REQ-001 SHALL have parameter HEIGHT, default 720, frame height in lines (multiple of 8).
REQ-002 SHALL have parameter STRIPS, default HEIGHT/8, number of 8-line strips per frame.
REQ-003 SHALL have parameter TIMEOUT, default 16384, maximum clk cycles allowed for one strip read.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port strip_rdy  input  2  one-cycle pulse per bank (bit b = bank b), strip written; already synchronised to clk.
REQ-007 SHALL have port frame_start  input  1  one-cycle pulse at frame start (vsync-derived, clk domain).
REQ-008 SHALL have port ds_ready  input  1  downstream DCT able to accept a full strip.
REQ-009 SHALL have port rd_done  input  1  one-cycle pulse from the read address generator, strip read complete.
REQ-010 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-011 SHALL have port rd_start  output  1  one-cycle pulse starting a strip read.
REQ-012 SHALL have port rd_bank  output  1  bank being read; held stable from rd_start until rd_done.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port strip_idx  output  $clog2(STRIPS)  index of the next strip to be read within the frame.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after the last strip of a frame completes.
REQ-016 SHALL have port overflow  output  1  sticky flag: a strip was written into a bank that was still full.
REQ-017 SHALL have port timeout_err  output  1  sticky flag: a read exceeded TIMEOUT cycles.

Function
REQ-018 SHALL keep one full flag per bank: set by strip_rdy[b]; cleared at rd_done of that bank, or by a timeout abort.
REQ-019 SHALL set overflow when strip_rdy[b] arrives while full[b] is already 1; full[b] stays 1 in that case.
REQ-020 SHALL give set priority when strip_rdy[b] and a clear of full[b] coincide: full[b]=1 and no overflow.
REQ-021 SHALL serve banks strictly in write order via a next_bank pointer; next_bank=0 after reset and after each applied frame_start, toggled on every strip completion.
REQ-022 SHALL implement the FSM IDLE -> ISSUE -> READ -> IDLE.
REQ-023 SHALL, in IDLE, go to ISSUE only when full[next_bank]=1 and ds_ready=1; a full non-next bank is never served.
REQ-024 SHALL, in ISSUE (one cycle), drive rd_start=1 with rd_bank=next_bank, then go to READ.
REQ-025 SHALL, in READ on rd_done: clear full[rd_bank], toggle next_bank, go to IDLE, and advance strip_idx.
REQ-026 SHALL, when the completing strip is STRIPS-1, wrap strip_idx to 0 and pulse frame_done on the cycle after rd_done.
REQ-027 SHALL count READ cycles; when the count reaches TIMEOUT without rd_done: set timeout_err, clear both full flags, go to IDLE, leave strip_idx and next_bank unchanged.
REQ-028 SHALL apply frame_start immediately in IDLE: strip_idx=0, next_bank=0, both full flags cleared; a strip_rdy in the same cycle is still recorded.
REQ-029 SHALL, for frame_start received in ISSUE or READ, latch it as pending and apply it on the cycle IDLE is re-entered, after the completion update.
REQ-030 SHALL clear overflow and timeout_err on clr_err; a new error in the same cycle wins.
REQ-031 SHALL ignore rd_done outside READ.

Reset
REQ-032 SHALL, on rst_n low, asynchronously force: state IDLE, full=00, next_bank=0, pending frame_start=0, timeout counter=0, rd_start=0, rd_bank=0, busy=0, strip_idx=0, frame_done=0, overflow=0, timeout_err=0.
REQ-033 SHALL, when rst_n is asserted mid-READ, drop the read with no rd_done expected; the read address generator is reset by the same rst_n.

Structure
REQ-034 SHALL place the state enum (IDLE, ISSUE, READ) and the constant STRIP_ROWS=8 in the shared package.
REQ-035 SHALL implement the per-bank set/clear/overflow flag as sub-module strip_full_flag, instantiated twice.

Verification
REQ-036 SHALL cover: strip_rdy=01, ds_ready=1 -> rd_start on the 2nd cycle with rd_bank=0; rd_done -> full[0]=0 and strip_idx=1.
REQ-037 SHALL cover: HEIGHT=16 (STRIPS=2), strips on bank 0 then bank 1 -> frame_done pulse once and strip_idx=0 after the second rd_done.
REQ-038 SHALL cover: strip_rdy=01 twice with no read in between -> overflow=1; clr_err -> overflow=0.
REQ-039 SHALL cover: ds_ready=0 with full=11 -> no rd_start; ds_ready=1 -> bank 0 read first, then bank 1.
REQ-040 SHALL cover: TIMEOUT=32, no rd_done -> timeout_err=1 at 32 READ cycles, state IDLE, full=00.
REQ-041 SHALL cover: frame_start mid-READ at strip_idx=5 -> on rd_done strip_idx=0, next_bank=0, full=00.

Source files
------------

// File: rtl/strip_scheduler_pkg.sv
// Shared constants and FSM state encoding for the strip read scheduler.
package strip_scheduler_pkg;

    localparam int unsigned STRIP_ROWS = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t READ  = 2'd2;

endpackage

// File: rtl/strip_full_flag.sv
// Per-bank "strip buffered" flag: set wins over clear, overflow on a set into a full bank.
module strip_full_flag (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    output logic full,
    output logic overflow_c
);

    // A coincident clear means the bank is being emptied this cycle, so the new strip fits.
    assign overflow_c = set & full & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else begin
            full <= set | (full & ~clr);
        end
    end

endmodule

// File: rtl/strip_scheduler.sv
// Ping-pong strip buffer read scheduler: issues one strip read per filled bank, in write order.
module strip_scheduler
    import strip_scheduler_pkg::*;
#(
    parameter int unsigned HEIGHT  = 720,
    parameter int unsigned STRIPS  = HEIGHT / STRIP_ROWS,
    parameter int unsigned TIMEOUT = 16384
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  strip_rdy,
    input  logic                        frame_start,
    input  logic                        ds_ready,
    input  logic                        rd_done,
    input  logic                        clr_err,
    output logic                        rd_start,
    output logic                        rd_bank,
    output logic                        busy,
    output logic [$clog2(STRIPS)-1:0]   strip_idx,
    output logic                        frame_done,
    output logic                        overflow,
    output logic                        timeout_err
);

    localparam int unsigned IDX_W = $clog2(STRIPS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_nx;
    logic [1:0]       full;
    logic [1:0]       full_clr;
    logic [1:0]       ovf_c;
    logic             next_bank;
    logic             pending;
    logic [CNT_W-1:0] tmo_cnt;

    logic complete_c;
    logic abort_c;
    logic fs_apply_c;
    logic last_c;

    assign complete_c = (state == READ) && rd_done;
    assign abort_c    = (state == READ) && !rd_done && (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign last_c     = (strip_idx == IDX_W'(STRIPS - 1));

    // Frame start acts at once in IDLE; otherwise it waits for the read to finish or abort.
    assign fs_apply_c = ((state == IDLE) && frame_start)
                      || ((complete_c || abort_c) && (pending || frame_start));

    assign full_clr[0] = fs_apply_c | abort_c | (complete_c && (rd_bank == 1'b0));
    assign full_clr[1] = fs_apply_c | abort_c | (complete_c && (rd_bank == 1'b1));

    strip_full_flag u_flag0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .set        (strip_rdy[0]),
        .clr        (full_clr[0]),
        .full       (full[0]),
        .overflow_c (ovf_c[0])
    );

    strip_full_flag u_flag1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .set        (strip_rdy[1]),
        .clr        (full_clr[1]),
        .full       (full[1]),
        .overflow_c (ovf_c[1])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (!frame_start && full[next_bank] && ds_ready) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = READ;
            end
            READ: begin
                if (complete_c || abort_c) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_start    <= 1'b0;
            rd_bank     <= 1'b0;
            busy        <= 1'b0;
            strip_idx   <= '0;
            frame_done  <= 1'b0;
            next_bank   <= 1'b0;
            pending     <= 1'b0;
            tmo_cnt     <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rd_start   <= (state_nx == ISSUE);
            busy       <= (state_nx != IDLE);
            frame_done <= complete_c && last_c;

            if ((state == IDLE) && (state_nx == ISSUE)) begin
                rd_bank <= next_bank;
            end

            if (fs_apply_c) begin
                next_bank <= 1'b0;
            end else if (complete_c) begin
                next_bank <= ~next_bank;
            end

            if (fs_apply_c) begin
                strip_idx <= '0;
            end else if (complete_c) begin
                strip_idx <= last_c ? '0 : strip_idx + IDX_W'(1);
            end

            if (fs_apply_c) begin
                pending <= 1'b0;
            end else if (frame_start && (state != IDLE)) begin
                pending <= 1'b1;
            end

            tmo_cnt <= (state == READ) ? tmo_cnt + CNT_W'(1) : '0;

            // New errors take precedence over a same-cycle clear.
            if (|ovf_c) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end

            if (abort_c) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_strip_scheduler.sv
// Directed bench: a 2-strip instance (a) and an 8-strip instance (b) share one stimulus stream.
module tb_strip_scheduler;

    logic       clk;
    logic       rst_n;
    logic [1:0] strip_rdy;
    logic       frame_start;
    logic       ds_ready;
    logic       rd_done;
    logic       clr_err;

    logic       a_rd_start, a_rd_bank, a_busy, a_frame_done, a_overflow, a_timeout_err;
    logic [0:0] a_strip_idx;
    logic       b_rd_start, b_rd_bank, b_busy, b_frame_done, b_overflow, b_timeout_err;
    logic [2:0] b_strip_idx;

    int n_pass;
    int n_total;

    strip_scheduler #(.HEIGHT(16), .TIMEOUT(32)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .strip_rdy   (strip_rdy),
        .frame_start (frame_start),
        .ds_ready    (ds_ready),
        .rd_done     (rd_done),
        .clr_err     (clr_err),
        .rd_start    (a_rd_start),
        .rd_bank     (a_rd_bank),
        .busy        (a_busy),
        .strip_idx   (a_strip_idx),
        .frame_done  (a_frame_done),
        .overflow    (a_overflow),
        .timeout_err (a_timeout_err)
    );

    strip_scheduler #(.HEIGHT(64), .TIMEOUT(32)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .strip_rdy   (strip_rdy),
        .frame_start (frame_start),
        .ds_ready    (ds_ready),
        .rd_done     (rd_done),
        .clr_err     (clr_err),
        .rd_start    (b_rd_start),
        .rd_bank     (b_rd_bank),
        .busy        (b_busy),
        .strip_idx   (b_strip_idx),
        .frame_done  (b_frame_done),
        .overflow    (b_overflow),
        .timeout_err (b_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst_n       = 1'b0;
        strip_rdy   = 2'b00;
        frame_start = 1'b0;
        ds_ready    = 1'b0;
        rd_done     = 1'b0;
        clr_err     = 1'b0;
        tick();
        tick();

        chk("rst_busy",     32'(a_busy), 32'd0);
        chk("rst_rd_start", 32'(a_rd_start), 32'd0);
        chk("rst_idx",      32'(b_strip_idx), 32'd0);
        chk("rst_errs",     32'({a_overflow, a_timeout_err, a_frame_done}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single strip on bank 0
        ds_ready  = 1'b1;
        strip_rdy = 2'b01;
        tick();
        strip_rdy = 2'b00;
        chk("s1_no_start_c1", 32'(a_rd_start), 32'd0);
        tick();
        chk("s1_rd_start", 32'(a_rd_start), 32'd1);
        chk("s1_rd_bank",  32'(a_rd_bank), 32'd0);
        chk("s1_busy",     32'(a_busy), 32'd1);
        tick();
        chk("s1_start_pulse", 32'(a_rd_start), 32'd0);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("s1_full",  32'(dut_a.full), 32'd0);
        chk("s1_idx_a", 32'(a_strip_idx), 32'd1);
        chk("s1_idle",  32'(a_busy), 32'd0);

        // Second strip on bank 1 closes the 2-strip frame
        strip_rdy = 2'b10;
        tick();
        strip_rdy = 2'b00;
        tick();
        chk("s2_rd_start", 32'(a_rd_start), 32'd1);
        chk("s2_rd_bank",  32'(a_rd_bank), 32'd1);
        tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("s2_frame_done", 32'(a_frame_done), 32'd1);
        chk("s2_idx_wrap",   32'(a_strip_idx), 32'd0);
        chk("s2_b_no_fd",    32'(b_frame_done), 32'd0);
        chk("s2_b_idx",      32'(b_strip_idx), 32'd2);
        tick();
        chk("s2_fd_once", 32'(a_frame_done), 32'd0);

        // Overflow: two writes into bank 0 with no read
        ds_ready  = 1'b0;
        strip_rdy = 2'b01;
        tick();
        chk("ovf_none_yet", 32'(a_overflow), 32'd0);
        tick();
        strip_rdy = 2'b00;
        chk("ovf_set",  32'(a_overflow), 32'd1);
        chk("ovf_full", 32'(dut_a.full), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_clr", 32'(a_overflow), 32'd0);

        // Both banks full, downstream stalled, then served in order
        strip_rdy = 2'b10;
        tick();
        strip_rdy = 2'b00;
        tick();
        tick();
        chk("stall_no_start", 32'(a_rd_start), 32'd0);
        chk("stall_idle",     32'(a_busy), 32'd0);
        ds_ready = 1'b1;
        tick();
        chk("ord_start0", 32'(a_rd_start), 32'd1);
        chk("ord_bank0",  32'(a_rd_bank), 32'd0);
        tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        tick();
        chk("ord_start1", 32'(a_rd_start), 32'd1);
        chk("ord_bank1",  32'(a_rd_bank), 32'd1);
        tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("ord_full_empty", 32'(dut_a.full), 32'd0);
        chk("ord_b_idx",      32'(b_strip_idx), 32'd4);

        // Non-next bank full is never served
        strip_rdy = 2'b10;
        tick();
        strip_rdy = 2'b00;
        tick();
        tick();
        chk("nonnext_idle", 32'(a_busy), 32'd0);

        // rd_done outside READ is ignored
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("stray_done_idx", 32'(b_strip_idx), 32'd4);

        // Timeout: read never completes
        strip_rdy = 2'b01;
        tick();
        strip_rdy = 2'b00;
        tick();
        chk("to_start_bank", 32'(a_rd_bank), 32'd0);
        tick();
        for (int i = 0; i < 31; i++) tick();
        chk("to_still_busy", 32'(a_busy), 32'd1);
        chk("to_not_yet",    32'(a_timeout_err), 32'd0);
        tick();
        chk("to_err",      32'(a_timeout_err), 32'd1);
        chk("to_idle",     32'(a_busy), 32'd0);
        chk("to_full_clr", 32'(dut_a.full), 32'd0);
        chk("to_idx_keep", 32'(b_strip_idx), 32'd4);
        chk("to_nb_keep",  32'(dut_b.next_bank), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_clr", 32'(a_timeout_err), 32'd0);

        // Advance instance b to strip 5
        strip_rdy = 2'b01;
        tick();
        strip_rdy = 2'b00;
        tick();
        tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("fs_idx5", 32'(b_strip_idx), 32'd5);

        // Frame start mid-read is held until the read completes
        strip_rdy = 2'b10;
        tick();
        strip_rdy = 2'b00;
        tick();
        chk("fs_bank1", 32'(b_rd_bank), 32'd1);
        tick();
        frame_start = 1'b1;
        strip_rdy   = 2'b01;
        tick();
        frame_start = 1'b0;
        strip_rdy   = 2'b00;
        chk("fs_held_idx", 32'(b_strip_idx), 32'd5);
        chk("fs_busy",     32'(b_busy), 32'd1);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("fs_idx0",  32'(b_strip_idx), 32'd0);
        chk("fs_nb0",   32'(dut_b.next_bank), 32'd0);
        chk("fs_full0", 32'(dut_b.full), 32'd0);
        chk("fs_no_fd", 32'(b_frame_done), 32'd0);

        // Frame start in IDLE with a same-cycle write keeps the write
        ds_ready    = 1'b0;
        frame_start = 1'b1;
        strip_rdy   = 2'b10;
        tick();
        frame_start = 1'b0;
        strip_rdy   = 2'b00;
        chk("fs_idle_keep", 32'(dut_b.full), 32'd2);
        chk("fs_idle_idx",  32'(b_strip_idx), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
